// File: rtl/buzzer_arbiter.sv
// Shares the single piezo buzzer pin between four priority-ranked tone patterns
// (tick, key click, alarm, success). Each pattern is generated from shared counters.
module buzzer_arbiter #(
    parameter int unsigned KEY_HALF  = 50000,
    parameter int unsigned KEY_LEN   = 10000000,
    parameter int unsigned TICK_HALF = 100000,
    parameter int unsigned TICK_LEN  = 5000000,
    parameter int unsigned FAIL_HALF = 100000,
    parameter int unsigned FAIL_GAP0 = 5000000,
    parameter int unsigned FAIL_GAP1 = 10000000,
    parameter int unsigned FAIL_LEN  = 15000000,
    parameter int unsigned OK_HALF   = 25000,
    parameter int unsigned OK_LEN    = 30000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       mute,
    output logic [3:0] ack,
    output logic       drop,
    output logic       busy,
    output logic [1:0] active_id,
    output logic       buzzer
);

    localparam int unsigned CNT_W = 32;

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    state_t             state_q, state_n;
    logic [CNT_W-1:0]   dur_q, dur_n;
    logic [CNT_W-1:0]   half_q, half_n;
    logic               tone_q, tone_n;
    logic [1:0]         id_n;
    logic [3:0]         ack_n;
    logic               drop_n, busy_n, buzzer_n;

    logic [1:0]         cand;
    logic               grant;
    logic [3:0]         win_oh;
    logic [CNT_W-1:0]   half_lim, len_lim;

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            dur_q     <= '0;
            half_q    <= '0;
            tone_q    <= 1'b0;
            active_id <= 2'd0;
            ack       <= 4'd0;
            drop      <= 1'b0;
            busy      <= 1'b0;
            buzzer    <= 1'b0;
        end else begin
            state_q   <= state_n;
            dur_q     <= dur_n;
            half_q    <= half_n;
            tone_q    <= tone_n;
            active_id <= id_n;
            ack       <= ack_n;
            drop      <= drop_n;
            busy      <= busy_n;
            buzzer    <= buzzer_n;
        end
    end

    // Arbitration, tone/duration sequencing and output decode
    always_comb begin
        state_n  = state_q;
        dur_n    = dur_q;
        half_n   = half_q;
        tone_n   = tone_q;
        id_n     = active_id;
        cand     = 2'd0;
        half_lim = CNT_W'(TICK_HALF - 1);
        len_lim  = CNT_W'(TICK_LEN - 1);

        if (req[3])      cand = 2'd3;
        else if (req[2]) cand = 2'd2;
        else if (req[1]) cand = 2'd1;

        grant  = (|req) && ((state_q == IDLE) || (cand >= active_id));
        win_oh = grant ? (4'(1) << cand) : 4'd0;

        case (active_id)
            2'd1: begin half_lim = CNT_W'(KEY_HALF - 1);  len_lim = CNT_W'(KEY_LEN - 1);  end
            2'd2: begin half_lim = CNT_W'(FAIL_HALF - 1); len_lim = CNT_W'(FAIL_LEN - 1); end
            2'd3: begin half_lim = CNT_W'(OK_HALF - 1);   len_lim = CNT_W'(OK_LEN - 1);   end
            default: ;
        endcase

        if (grant) begin
            state_n = PLAY;
            id_n    = cand;
            dur_n   = '0;
            half_n  = '0;
            tone_n  = 1'b1;
        end else if (state_q != IDLE) begin
            if (half_q == half_lim) begin
                half_n = '0;
                tone_n = ~tone_q;
            end else begin
                half_n = half_q + CNT_W'(1);
            end

            if (dur_q == len_lim) begin
                state_n = IDLE;
                id_n    = 2'd0;
                dur_n   = '0;
                half_n  = '0;
                tone_n  = 1'b0;
            end else begin
                dur_n = dur_q + CNT_W'(1);
                // Alarm has a silent window in the middle; the tone keeps running through it
                if (active_id == 2'd2) begin
                    if (state_q == PLAY && dur_q == CNT_W'(FAIL_GAP0 - 1)) state_n = GAP;
                    if (state_q == GAP  && dur_q == CNT_W'(FAIL_GAP1 - 1)) state_n = PLAY;
                end
            end
        end

        ack_n    = win_oh;
        drop_n   = |(req & ~win_oh);
        busy_n   = (state_n != IDLE);
        buzzer_n = tone_n & (state_n == PLAY) & ~mute;
    end

endmodule
